// File: rtl/irrig_scheduler_if.sv
// irrig_scheduler_if: raw field sensors and fertilize request in,
// irrigation command and fault levels out.
interface irrig_scheduler_if;
   logic [1:0] Us;
   logic       Ta;
   logic       Nv1;
   logic       Nv0;
   logic       Adub_req;
   logic       Asp;
   logic       Got;
   logic       Adub;
   logic       Falha;

   modport master (
      output Us, Ta, Nv1, Nv0, Adub_req,
      input  Asp, Got, Adub, Falha
   );

   modport slave (
      input  Us, Ta, Nv1, Nv0, Adub_req,
      output Asp, Got, Adub, Falha
   );
endinterface

// File: rtl/irrig_scheduler.sv
// irrig_scheduler: debounces field sensors and decides between
// sprinkler and drip runs, with run/cool-down timers and fault lockout.
module irrig_scheduler #(
   parameter int DEB_CYC   = 8,
   parameter int MAX_IRR   = 1000,
   parameter int PAUSE_CYC = 200,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   irrig_scheduler_if.slave  bus
);

   localparam int DW = $clog2(DEB_CYC + 1);

   typedef struct packed {
      logic [1:0]    filt;
      logic [1:0]    cand;
      logic [DW-1:0] cnt;
   } deb_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ASP,
      S_GOT,
      S_PAUSA,
      S_FALHA
   } state_t;

   // Channel 0 is Us; 1..3 are Ta, Nv1, Nv0 padded to 2 bits.
   logic [1:0] raw   [4];
   deb_t       deb_q [4];
   deb_t       deb_d [4];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             adub_pend_q, adub_pend_d;
   logic             adub_q, adub_d;
   logic             asp_q, asp_d;
   logic             got_q, got_d;
   logic             falha_q, falha_d;

   logic [1:0] us_f;
   logic       ta_f;
   logic       empty;
   logic       fault;
   logic       run_end;
   logic       pause_end;
   logic       start;

   // A candidate must repeat DEB_CYC samples in a row to replace
   // the filtered value; any other sample restarts the count.
   function automatic deb_t deb_step(deb_t cur, logic [1:0] smp);
      deb_t nxt;
      nxt = cur;
      if (smp == cur.filt) begin
         nxt.cnt = '0;
      end else if (cur.cnt != '0 && smp == cur.cand) begin
         if (cur.cnt >= DW'(DEB_CYC - 1)) begin
            nxt.filt = smp;
            nxt.cnt  = '0;
         end else begin
            nxt.cnt = cur.cnt + DW'(1);
         end
      end else begin
         nxt.cand = smp;
         if (DEB_CYC <= 1) begin
            nxt.filt = smp;
            nxt.cnt  = '0;
         end else begin
            nxt.cnt = DW'(1);
         end
      end
      return nxt;
   endfunction

   // Debounce next-state for every sensor channel.
   always_comb begin
      raw[0] = bus.Us;
      raw[1] = {1'b0, bus.Ta};
      raw[2] = {1'b0, bus.Nv1};
      raw[3] = {1'b0, bus.Nv0};
      for (int i = 0; i < 4; i++) begin
         deb_d[i] = deb_step(deb_q[i], raw[i]);
      end
   end

   // Debounce registers; tank levels reset to full, others to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            deb_q[i] <= deb_t'{
               filt: (i >= 2) ? 2'b01 : 2'b00,
               cand: (i >= 2) ? 2'b01 : 2'b00,
               cnt:  '0
            };
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            deb_q[i] <= deb_d[i];
         end
      end
   end

   // Filtered conditions that drive every decision.
   always_comb begin
      us_f      = deb_q[0].filt;
      ta_f      = deb_q[1].filt != 2'b00;
      empty     = deb_q[2].filt == 2'b00 &&
                  deb_q[3].filt == 2'b00;
      fault     = us_f == 2'b11;
      run_end   = timer_q == CNT_W'(MAX_IRR - 1);
      pause_end = timer_q == CNT_W'(PAUSE_CYC - 1);
   end

   // Next state, timer, fertilize bookkeeping and output decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (fault) begin
               state_d = S_FALHA;
            end else if (us_f == 2'b10 && !empty) begin
               state_d = ta_f ? S_GOT : S_ASP;
            end
         end
         S_ASP, S_GOT: begin
            if (fault) begin
               state_d = S_FALHA;
            end else if (us_f == 2'b00 || empty || run_end) begin
               state_d = S_PAUSA;
            end
         end
         S_PAUSA: begin
            if (fault) begin
               state_d = S_FALHA;
            end else if (pause_end) begin
               state_d = S_IDLE;
            end
         end
         S_FALHA: begin
            if (!fault && pause_end) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // In lockout the timer counts only clean (non-fault) cycles.
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (state_q == S_FALHA && fault) begin
         timer_d = '0;
      end else if (!(&timer_q)) begin
         timer_d = timer_q + CNT_W'(1);
      end

      start = state_q == S_IDLE &&
              (state_d == S_ASP || state_d == S_GOT);

      adub_pend_d = (adub_pend_q & ~start) | bus.Adub_req;

      adub_d = adub_q;
      if (start) begin
         adub_d = adub_pend_q | bus.Adub_req;
      end else if (state_d != state_q &&
                   (state_d == S_PAUSA || state_d == S_FALHA)) begin
         adub_d = 1'b0;
      end

      asp_d   = state_d == S_ASP;
      got_d   = state_d == S_GOT;
      falha_d = state_d == S_FALHA;
   end

   // State, timer and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         adub_pend_q <= 1'b0;
         adub_q      <= 1'b0;
         asp_q       <= 1'b0;
         got_q       <= 1'b0;
         falha_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         adub_pend_q <= adub_pend_d;
         adub_q      <= adub_d;
         asp_q       <= asp_d;
         got_q       <= got_d;
         falha_q     <= falha_d;
      end
   end

   assign bus.Asp   = asp_q;
   assign bus.Got   = got_q;
   assign bus.Adub  = adub_q;
   assign bus.Falha = falha_q;

endmodule
